// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: line geometry defaults and
// the arbiter state encoding.
package mem_arbiter_pkg;

    localparam int unsigned MEM_ADDR_BITS_DEF = 28;
    localparam int unsigned MEM_DATA_BITS_DEF = 128;
    localparam int unsigned BEATS_PER_LINE    = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_IC_RD = 2'd1,
        ARB_DC_RD = 2'd2,
        ARB_DC_WR = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant. rr_last remembers the index granted most
// recently; on contention the other requester wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic rr_last_q;
    logic rr_last_d;

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (req == 2'b11) ? ~rr_last_q : req[1];
        rr_last_d = rr_last_q;
        if (take && gnt_valid) begin
            rr_last_d = gnt_idx;
        end
    end

    // NOTE: reset is sampled on the clock edge here, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between icache (read only) and dcache, holding
// ownership for a whole line and re-arbitrating round-robin between lines.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_ADDR_BITS = MEM_ADDR_BITS_DEF,
    parameter int MEM_DATA_BITS = MEM_DATA_BITS_DEF,
    parameter int BEATS         = BEATS_PER_LINE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ic_mem_req_valid,
    output logic                       ic_mem_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   ic_mem_req_addr,
    output logic                       ic_mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   ic_mem_resp_data,
    input  logic                       dc_mem_req_valid,
    output logic                       dc_mem_req_ready,
    input  logic [MEM_ADDR_BITS-1:0]   dc_mem_req_addr,
    input  logic                       dc_mem_req_rw,
    input  logic                       dc_mem_req_data_valid,
    output logic                       dc_mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]   dc_mem_req_data_bits,
    input  logic [MEM_DATA_BITS/8-1:0] dc_mem_req_data_mask,
    output logic                       dc_mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0]   dc_mem_resp_data,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [MEM_ADDR_BITS-1:0]   mem_req_addr,
    output logic                       mem_req_rw,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [MEM_DATA_BITS-1:0]   mem_req_data_bits,
    output logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                       mem_resp_valid,
    input  logic [MEM_DATA_BITS-1:0]   mem_resp_data
);

    localparam int CNT_BITS = $clog2(BEATS);
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

    arb_state_e          state_q, state_d;
    logic [CNT_BITS-1:0] beat_cnt_q, beat_cnt_d;
    logic                req_done_q, req_done_d;
    logic                data_done_q, data_done_d;

    logic arb_take, gnt_valid, gnt_dc;
    logic owner_dc, last_beat, req_fire, data_fire;

    rr_arbiter2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       ({dc_mem_req_valid, ic_mem_req_valid}),
        .take      (arb_take),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_dc)
    );

    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        req_done_d  = req_done_q;
        data_done_d = data_done_q;
        arb_take    = 1'b0;
        req_fire    = 1'b0;
        data_fire   = 1'b0;
        owner_dc    = (state_q == ARB_DC_RD) || (state_q == ARB_DC_WR);
        last_beat   = (beat_cnt_q == LAST_BEAT);

        ic_mem_req_ready      = 1'b0;
        ic_mem_resp_valid     = 1'b0;
        ic_mem_resp_data      = '0;
        dc_mem_req_ready      = 1'b0;
        dc_mem_req_data_ready = 1'b0;
        dc_mem_resp_valid     = 1'b0;
        dc_mem_resp_data      = '0;
        mem_req_valid         = 1'b0;
        mem_req_addr          = '0;
        mem_req_rw            = 1'b0;
        mem_req_data_valid    = 1'b0;
        mem_req_data_bits     = '0;
        mem_req_data_mask     = '0;

        if (state_q == ARB_IDLE) begin
            arb_take    = 1'b1;
            beat_cnt_d  = '0;
            req_done_d  = 1'b0;
            data_done_d = 1'b0;
            if (gnt_valid) begin
                if (!gnt_dc)           state_d = ARB_IC_RD;
                else if (dc_mem_req_rw) state_d = ARB_DC_WR;
                else                   state_d = ARB_DC_RD;
            end
        end else begin
            // One request per line: req_done masks any repeat from the owner.
            mem_req_valid    = (owner_dc ? dc_mem_req_valid : ic_mem_req_valid) & ~req_done_q;
            mem_req_addr     = owner_dc ? dc_mem_req_addr : ic_mem_req_addr;
            mem_req_rw       = owner_dc & dc_mem_req_rw;
            ic_mem_req_ready = ~owner_dc & mem_req_ready & ~req_done_q;
            dc_mem_req_ready = owner_dc & mem_req_ready & ~req_done_q;
            req_fire         = mem_req_valid & mem_req_ready;
            if (req_fire) begin
                req_done_d = 1'b1;
            end

            if (state_q == ARB_DC_WR) begin
                // Write data may run ahead of the request; data_done stops a fifth beat.
                mem_req_data_valid    = dc_mem_req_data_valid & ~data_done_q;
                mem_req_data_bits     = dc_mem_req_data_bits;
                mem_req_data_mask     = dc_mem_req_data_mask;
                dc_mem_req_data_ready = mem_req_data_ready & ~data_done_q;
                data_fire             = mem_req_data_valid & mem_req_data_ready;
                if (data_fire) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat) data_done_d = 1'b1;
                end
                if ((req_done_q || req_fire) && (data_done_q || (data_fire && last_beat))) begin
                    state_d = ARB_IDLE;
                end
            end else begin
                ic_mem_resp_valid = ~owner_dc & mem_resp_valid;
                ic_mem_resp_data  = owner_dc ? '0 : mem_resp_data;
                dc_mem_resp_valid = owner_dc & mem_resp_valid;
                dc_mem_resp_data  = owner_dc ? mem_resp_data : '0;
                if (mem_resp_valid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat && (req_done_q || req_fire)) state_d = ARB_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            beat_cnt_q  <= '0;
            req_done_q  <= 1'b0;
            data_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            req_done_q  <= req_done_d;
            data_done_q <= data_done_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected requests, write beats and
// response beats are queued as stimulus is driven and checked at negedge.
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ic_mem_req_valid, ic_mem_req_ready;
    logic [AW-1:0] ic_mem_req_addr;
    logic          ic_mem_resp_valid;
    logic [DW-1:0] ic_mem_resp_data;
    logic          dc_mem_req_valid, dc_mem_req_ready;
    logic [AW-1:0] dc_mem_req_addr;
    logic          dc_mem_req_rw;
    logic          dc_mem_req_data_valid, dc_mem_req_data_ready;
    logic [DW-1:0] dc_mem_req_data_bits;
    logic [MW-1:0] dc_mem_req_data_mask;
    logic          dc_mem_resp_valid;
    logic [DW-1:0] dc_mem_resp_data;
    logic          mem_req_valid, mem_req_ready;
    logic [AW-1:0] mem_req_addr;
    logic          mem_req_rw;
    logic          mem_req_data_valid, mem_req_data_ready;
    logic [DW-1:0] mem_req_data_bits;
    logic [MW-1:0] mem_req_data_mask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;

    mem_arbiter #(.MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW), .BEATS(4)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ic_mem_req_valid      (ic_mem_req_valid),
        .ic_mem_req_ready      (ic_mem_req_ready),
        .ic_mem_req_addr       (ic_mem_req_addr),
        .ic_mem_resp_valid     (ic_mem_resp_valid),
        .ic_mem_resp_data      (ic_mem_resp_data),
        .dc_mem_req_valid      (dc_mem_req_valid),
        .dc_mem_req_ready      (dc_mem_req_ready),
        .dc_mem_req_addr       (dc_mem_req_addr),
        .dc_mem_req_rw         (dc_mem_req_rw),
        .dc_mem_req_data_valid (dc_mem_req_data_valid),
        .dc_mem_req_data_ready (dc_mem_req_data_ready),
        .dc_mem_req_data_bits  (dc_mem_req_data_bits),
        .dc_mem_req_data_mask  (dc_mem_req_data_mask),
        .dc_mem_resp_valid     (dc_mem_resp_valid),
        .dc_mem_resp_data      (dc_mem_resp_data),
        .mem_req_valid         (mem_req_valid),
        .mem_req_ready         (mem_req_ready),
        .mem_req_addr          (mem_req_addr),
        .mem_req_rw            (mem_req_rw),
        .mem_req_data_valid    (mem_req_data_valid),
        .mem_req_data_ready    (mem_req_data_ready),
        .mem_req_data_bits     (mem_req_data_bits),
        .mem_req_data_mask     (mem_req_data_mask),
        .mem_resp_valid        (mem_resp_valid),
        .mem_resp_data         (mem_resp_data)
    );

    always #5 clk = ~clk;

    logic [DW-1:0]    exp_ic_q[$];
    logic [DW-1:0]    exp_dc_q[$];
    logic [AW:0]      exp_req_q[$];
    logic [DW+MW-1:0] exp_wd_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0]    m_data;
    logic [AW:0]      m_req;
    logic [DW+MW-1:0] m_wd;

    // Every beat or handshake the DUT produces must match the head of its queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (ic_mem_resp_valid) begin
                n_cmp++;
                if (exp_ic_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL ic_resp_unexpected: got beat %h, required none", ic_mem_resp_data);
                end else begin
                    m_data = exp_ic_q.pop_front();
                    if (ic_mem_resp_data !== m_data) begin
                        n_bad++;
                        $display("FAIL ic_resp_data: got %h, required %h", ic_mem_resp_data, m_data);
                    end
                end
            end
            if (dc_mem_resp_valid) begin
                n_cmp++;
                if (exp_dc_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL dc_resp_unexpected: got beat %h, required none", dc_mem_resp_data);
                end else begin
                    m_data = exp_dc_q.pop_front();
                    if (dc_mem_resp_data !== m_data) begin
                        n_bad++;
                        $display("FAIL dc_resp_data: got %h, required %h", dc_mem_resp_data, m_data);
                    end
                end
            end
            if (mem_req_valid && mem_req_ready) begin
                n_cmp++;
                if (exp_req_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL mem_req_unexpected: got rw=%0b addr=%h, required none", mem_req_rw, mem_req_addr);
                end else begin
                    m_req = exp_req_q.pop_front();
                    if ({mem_req_rw, mem_req_addr} !== m_req) begin
                        n_bad++;
                        $display("FAIL mem_req: got %h, required %h", {mem_req_rw, mem_req_addr}, m_req);
                    end
                end
            end
            if (mem_req_data_valid && mem_req_data_ready) begin
                n_cmp++;
                if (exp_wd_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL wdata_unexpected: got %h, required none", mem_req_data_bits);
                end else begin
                    m_wd = exp_wd_q.pop_front();
                    if ({mem_req_data_bits, mem_req_data_mask} !== m_wd) begin
                        n_bad++;
                        $display("FAIL wdata: got %h, required %h", {mem_req_data_bits, mem_req_data_mask}, m_wd);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] ctrl();
        return {ic_mem_req_ready, ic_mem_resp_valid, dc_mem_req_ready, dc_mem_req_data_ready,
                dc_mem_resp_valid, mem_req_valid, mem_req_data_valid};
    endfunction

    task automatic clear_inputs();
        ic_mem_req_valid = 0; ic_mem_req_addr = '0;
        dc_mem_req_valid = 0; dc_mem_req_addr = '0; dc_mem_req_rw = 0;
        dc_mem_req_data_valid = 0; dc_mem_req_data_bits = '0; dc_mem_req_data_mask = '0;
        mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
    endtask

    // Entered in the first owned cycle with the owner's valid already high;
    // returns in the IDLE cycle that follows the fourth response beat.
    task automatic serve_read(input bit dc, input logic [AW-1:0] addr, input bit hold);
        logic [DW-1:0] d;
        mem_req_ready = 1;
        #1;
        n_cmp++;
        if ({ic_mem_req_ready, dc_mem_req_ready} !== (dc ? 2'b01 : 2'b10)) begin
            n_bad++;
            $display("FAIL grant: got ready ic/dc=%b, required %b", {ic_mem_req_ready, dc_mem_req_ready}, dc ? 2'b01 : 2'b10);
        end
        exp_req_q.push_back({1'b0, addr});
        cyc();
        if (!hold) begin
            if (dc) dc_mem_req_valid = 0; else ic_mem_req_valid = 0;
        end
        for (int i = 0; i < 4; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            mem_resp_valid = 1;
            mem_resp_data  = d;
            if (dc) exp_dc_q.push_back(d); else exp_ic_q.push_back(d);
            #1;
            n_cmp++;
            if (mem_req_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL dup_request: got mem_req_valid=%b on beat %0d, required 0", mem_req_valid, i);
            end
            cyc();
        end
        mem_resp_valid = 0;
        #1;
        n_cmp++;
        if (ctrl() !== 7'b0) begin
            n_bad++;
            $display("FAIL idle_after_line: got ctrl=%b, required 0000000", ctrl());
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        ic_mem_req_valid = 1;
        dc_mem_req_valid = 1;
        repeat (3) cyc();
        n_cmp++;
        if (ctrl() !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b, required 0000000", ctrl());
        end
        reset = 0;
        ic_mem_req_valid = 0;
        dc_mem_req_valid = 0;
        #1;
        n_cmp++;
        if ({mem_req_addr, mem_req_rw, mem_req_data_bits, mem_req_data_mask, ic_mem_resp_data, dc_mem_resp_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got addr=%h mask=%h, required all zero", mem_req_addr, mem_req_data_mask);
        end
    endtask

    task automatic test_contention();
        cyc();
        ic_mem_req_valid = 1; ic_mem_req_addr = 28'h1111110;
        dc_mem_req_valid = 1; dc_mem_req_addr = 28'h2222220; dc_mem_req_rw = 0;
        #1;
        n_cmp++;
        if (ctrl() !== 7'b0) begin
            n_bad++;
            $display("FAIL arb_latency: got ctrl=%b, required 0000000", ctrl());
        end
        cyc();
        serve_read(1, 28'h2222220, 0);
        cyc();
        serve_read(0, 28'h1111110, 0);
    endtask

    task automatic test_ic_read();
        cyc();
        ic_mem_req_valid = 1; ic_mem_req_addr = 28'h0000123;
        cyc();
        serve_read(0, 28'h0000123, 0);
        mem_resp_valid = 1;
        mem_resp_data  = '1;
        #1;
        n_cmp++;
        if ({ic_mem_resp_valid, dc_mem_resp_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_resp_drop: got resp ic/dc=%b, required 00", {ic_mem_resp_valid, dc_mem_resp_valid});
        end
        cyc();
        mem_resp_valid = 0;
    endtask

    task automatic test_back_to_back();
        ic_mem_req_valid = 1; ic_mem_req_addr = 28'h0C0C0C0;
        dc_mem_req_valid = 1; dc_mem_req_addr = 28'h0D0D0D0; dc_mem_req_rw = 0;
        cyc();
        serve_read(1, 28'h0D0D0D0, 1);
        cyc();
        serve_read(0, 28'h0C0C0C0, 1);
        cyc();
        serve_read(1, 28'h0D0D0D0, 1);
        ic_mem_req_valid = 0;
        dc_mem_req_valid = 0;
        cyc();
    endtask

    task automatic test_write_coincident();
        bit pat[6] = '{0, 1, 0, 1, 0, 1};
        int beat = 2;
        dc_mem_req_valid = 1; dc_mem_req_rw = 1; dc_mem_req_addr = 28'h0ABCDE0;
        cyc();
        mem_req_ready = 1; mem_req_data_ready = 1;
        dc_mem_req_data_valid = 1; dc_mem_req_data_bits = 128'h1; dc_mem_req_data_mask = '1;
        mem_resp_valid = 1; mem_resp_data = 128'hBAD;
        exp_req_q.push_back({1'b1, 28'h0ABCDE0});
        exp_wd_q.push_back({128'h1, {MW{1'b1}}});
        #1;
        n_cmp++;
        if ({dc_mem_req_ready, dc_mem_req_data_ready, dc_mem_resp_valid} !== 3'b110) begin
            n_bad++;
            $display("FAIL wr_first: got req/data ready, resp=%b, required 110", {dc_mem_req_ready, dc_mem_req_data_ready, dc_mem_resp_valid});
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            dc_mem_req_valid = 0;
            mem_resp_valid = 0;
            mem_req_data_ready = pat[i];
            dc_mem_req_data_bits = DW'(beat);
            if (pat[i]) exp_wd_q.push_back({DW'(beat), {MW{1'b1}}});
            #1;
            n_cmp++;
            if (dc_mem_req_data_ready !== pat[i]) begin
                n_bad++;
                $display("FAIL wr_data_ready: got %b, required %b", dc_mem_req_data_ready, pat[i]);
            end
            if (pat[i]) beat++;
        end
        cyc();
        dc_mem_req_data_bits = 128'h5;
        mem_req_data_ready = 1;
        #1;
        n_cmp++;
        if (ctrl() !== 7'b0) begin
            n_bad++;
            $display("FAIL wr_idle_after_4: got ctrl=%b, required 0000000", ctrl());
        end
        cyc();
        clear_inputs();
    endtask

    task automatic test_write_early();
        dc_mem_req_valid = 1; dc_mem_req_rw = 1; dc_mem_req_addr = 28'h0F00F00;
        cyc();
        mem_req_ready = 0; mem_req_data_ready = 1;
        for (int i = 0; i < 4; i++) begin
            dc_mem_req_data_valid = 1;
            dc_mem_req_data_bits  = DW'(10 + i);
            dc_mem_req_data_mask  = 16'h5A5A ^ MW'(i);
            exp_wd_q.push_back({DW'(10 + i), 16'h5A5A ^ MW'(i)});
            #1;
            n_cmp++;
            if (mem_req_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL wr_req_pending: got mem_req_valid=%b, required 1", mem_req_valid);
            end
            cyc();
        end
        dc_mem_req_data_bits = DW'(99);
        mem_req_ready = 1;
        exp_req_q.push_back({1'b1, 28'h0F00F00});
        #1;
        n_cmp++;
        if ({dc_mem_req_data_ready, mem_req_data_valid} !== 2'b00) begin
            n_bad++;
            $display("FAIL wr_data_overrun: got data ready/valid=%b, required 00", {dc_mem_req_data_ready, mem_req_data_valid});
        end
        cyc();
        dc_mem_req_valid = 0;
        #1;
        n_cmp++;
        if (ctrl() !== 7'b0) begin
            n_bad++;
            $display("FAIL wr_early_idle: got ctrl=%b, required 0000000", ctrl());
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        cyc();
        ic_mem_req_valid = 1; ic_mem_req_addr = 28'h0E0E0E0;
        cyc();
        mem_req_ready = 1;
        exp_req_q.push_back({1'b0, 28'h0E0E0E0});
        cyc();
        ic_mem_req_valid = 0;
        for (int i = 0; i < 2; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            mem_resp_valid = 1; mem_resp_data = d;
            exp_ic_q.push_back(d);
            cyc();
        end
        reset = 1;
        mem_resp_valid = 0;
        cyc();
        reset = 0;
        for (int i = 0; i < 2; i++) begin
            mem_resp_valid = 1; mem_resp_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            #1;
            n_cmp++;
            if ({ic_mem_resp_valid, dc_mem_resp_valid} !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_mid_drop: got resp ic/dc=%b, required 00", {ic_mem_resp_valid, dc_mem_resp_valid});
            end
            cyc();
        end
        mem_resp_valid = 0;
    endtask

    task automatic test_drain();
        n_cmp++;
        if (exp_ic_q.size() + exp_dc_q.size() + exp_req_q.size() + exp_wd_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d/%0d/%0d pending ic/dc/req/wdata, required 0",
                     exp_ic_q.size(), exp_dc_q.size(), exp_req_q.size(), exp_wd_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_contention();
        test_ic_read();
        test_back_to_back();
        test_write_coincident();
        test_write_early();
        test_reset_mid();
        repeat (2) cyc();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
